usb_packet_parser: RTL and testbench

- Downstream consumer of the USB receive stage.
- The receiver fills the shared 256x32 packet buffer and pulses ready with a byte count. This block then reads the buffer back, validates the PID check nibble and CRC5/CRC16, and decodes token fields.
- It presents one decoded result per packet to the core-side logic with a valid/ready handshake, then releases the buffer back to the receiver.

---
 rtl/usb_pkg.sv | 50 +++++
 rtl/usb_packet_parser_if.sv | 35 +++
 rtl/usb_crc_byte.sv | 28 ++
 rtl/usb_packet_parser.sv | 218 +++++++++++++++++++++
 tb/tb_usb_packet_parser.sv | 246 ++++++++++++++++++++++++
 5 files changed

// File: rtl/usb_pkg.sv
// Shared USB constants: PID codes, packet kinds, CRC parameters and parser states.
package usb_pkg;

    localparam logic [7:0] PID_OUT   = 8'hE1;
    localparam logic [7:0] PID_IN    = 8'h69;
    localparam logic [7:0] PID_SETUP = 8'h2D;
    localparam logic [7:0] PID_SOF   = 8'hA5;
    localparam logic [7:0] PID_DATA0 = 8'hC3;
    localparam logic [7:0] PID_DATA1 = 8'h4B;
    localparam logic [7:0] PID_ACK   = 8'hD2;
    localparam logic [7:0] PID_NAK   = 8'h5A;
    localparam logic [7:0] PID_STALL = 8'h1E;

    typedef enum logic [1:0] {
        KIND_TOKEN     = 2'd0,
        KIND_DATA      = 2'd1,
        KIND_HANDSHAKE = 2'd2,
        KIND_SPECIAL   = 2'd3
    } kind_e;

    localparam logic [4:0]  CRC5_POLY      = 5'h05;
    localparam logic [4:0]  CRC5_INIT      = 5'h1F;
    localparam logic [4:0]  CRC5_RESIDUAL  = 5'h0C;
    localparam logic [15:0] CRC16_POLY     = 16'h8005;
    localparam logic [15:0] CRC16_INIT     = 16'hFFFF;
    localparam logic [15:0] CRC16_RESIDUAL = 16'h800D;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_FETCH  = 2'd1,
        ST_PARSE  = 2'd2,
        ST_RESULT = 2'd3
    } state_e;

    function automatic kind_e pid_kind(input logic [7:0] b);
        kind_e k;
        case (b)
            PID_OUT, PID_IN, PID_SETUP, PID_SOF: k = KIND_TOKEN;
            PID_DATA0, PID_DATA1:                k = KIND_DATA;
            PID_ACK, PID_NAK, PID_STALL:         k = KIND_HANDSHAKE;
            default:                             k = KIND_SPECIAL;
        endcase
        return k;
    endfunction

    function automatic logic pid_check(input logic [7:0] b);
        return b[7:4] == ~b[3:0];
    endfunction

endpackage

// File: rtl/usb_packet_parser_if.sv
// Parser-facing bundle: start/length from the receiver, buffer read port, decoded result handshake.
// master = receiver/core side, slave = parser.
interface usb_packet_parser_if #(
    parameter int AW = 8
);
    logic          start;
    logic [10:0]   packet_bytes;
    logic [AW-1:0] buf_addr;
    logic [31:0]   buf_rdata;
    logic          busy;
    logic          buf_release;
    logic          result_valid;
    logic          result_ready;
    logic [3:0]    pid;
    logic [1:0]    kind;
    logic          pid_ok;
    logic          crc_ok;
    logic          len_ok;
    logic [6:0]    addr;
    logic [3:0]    endp;
    logic [10:0]   frame;
    logic [10:0]   payload_bytes;

    modport master (
        output start, packet_bytes, buf_rdata, result_ready,
        input  buf_addr, busy, buf_release, result_valid, pid, kind,
               pid_ok, crc_ok, len_ok, addr, endp, frame, payload_bytes
    );

    modport slave (
        input  start, packet_bytes, buf_rdata, result_ready,
        output buf_addr, busy, buf_release, result_valid, pid, kind,
               pid_ok, crc_ok, len_ok, addr, endp, frame, payload_bytes
    );
endinterface

// File: rtl/usb_crc_byte.sv
// One byte of USB CRC5 and CRC16, bits taken LSB-first; purely combinational.
// Zero latency, no flow control.
module usb_crc_byte
    import usb_pkg::*;
(
    input  logic [4:0]  i_crc5,
    input  logic [15:0] i_crc16,
    input  logic [7:0]  i_data,
    output logic [4:0]  o_crc5,
    output logic [15:0] o_crc16
);

    logic [4:0]  w_c5;
    logic [15:0] w_c16;

    always_comb begin
        w_c5  = i_crc5;
        w_c16 = i_crc16;
        for (int i = 0; i < 8; i++) begin
            w_c5  = {w_c5[3:0], 1'b0} ^ ((w_c5[4] ^ i_data[i]) ? CRC5_POLY : 5'd0);
            w_c16 = {w_c16[14:0], 1'b0} ^ ((w_c16[15] ^ i_data[i]) ? CRC16_POLY : 16'd0);
        end
    end

    assign o_crc5  = w_c5;
    assign o_crc16 = w_c16;

endmodule

// File: rtl/usb_packet_parser.sv
// Reads a received packet back from the shared buffer, checks PID/CRC/length and decodes token fields.
// Result valid N+2 cycles after start; result held until result_ready, start ignored while busy.
module usb_packet_parser
    import usb_pkg::*;
#(
    parameter int BUF_WORDS = 256,
    parameter int MAX_BYTES = 1024
)(
    input logic               clock48,
    input logic               reset_n,
    usb_packet_parser_if.slave io
);

    localparam int          AW      = $clog2(BUF_WORDS);
    localparam logic [10:0] MAX_LEN = 11'(MAX_BYTES);

    state_e        r_state;
    state_e        w_state_nxt;
    logic [10:0]   r_len;
    logic [10:0]   r_idx;
    logic [AW-1:0] r_buf_addr;
    logic [4:0]    r_crc5;
    logic [15:0]   r_crc16;
    logic [4:0]    w_crc5_nxt;
    logic [15:0]   w_crc16_nxt;
    logic [7:0]    w_byte;

    logic          w_accept;
    logic          w_consume;
    logic          w_finish;
    logic          w_done;
    logic          w_len_ok;
    logic          w_crc_ok;
    logic [10:0]   w_payload;

    logic          r_busy;
    logic          r_buf_release;
    logic          r_result_valid;
    logic [3:0]    r_pid;
    kind_e         r_kind;
    logic          r_pid_ok;
    logic          r_crc_ok;
    logic          r_len_ok;
    logic [6:0]    r_addr;
    logic [3:0]    r_endp;
    logic [10:0]   r_frame;
    logic [10:0]   r_payload;

    assign w_byte = io.buf_rdata[{r_idx[1:0], 3'b000} +: 8];

    usb_crc_byte u_crc (
        .i_crc5  (r_crc5),
        .i_crc16 (r_crc16),
        .i_data  (w_byte),
        .o_crc5  (w_crc5_nxt),
        .o_crc16 (w_crc16_nxt)
    );

    always_ff @(posedge clock48 or negedge reset_n) begin
        if (!reset_n) r_state <= ST_IDLE;
        else          r_state <= w_state_nxt;
    end

    // PARSE lasts N+1 cycles: N byte cycles plus one cycle that judges the registered CRCs.
    always_comb begin
        w_state_nxt = r_state;
        w_accept    = 1'b0;
        w_consume   = 1'b0;
        w_finish    = 1'b0;
        w_done      = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (io.start) begin
                    w_accept    = 1'b1;
                    w_state_nxt = (io.packet_bytes == 11'd0) ? ST_RESULT : ST_FETCH;
                end
            end
            ST_FETCH: w_state_nxt = ST_PARSE;
            ST_PARSE: begin
                if (r_idx == r_len) begin
                    w_finish    = 1'b1;
                    w_state_nxt = ST_RESULT;
                end else begin
                    w_consume = 1'b1;
                end
            end
            ST_RESULT: begin
                if (io.result_ready) begin
                    w_done      = 1'b1;
                    w_state_nxt = ST_IDLE;
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    always_comb begin
        w_len_ok  = 1'b0;
        w_crc_ok  = 1'b0;
        w_payload = 11'd0;
        case (r_kind)
            KIND_TOKEN: begin
                w_len_ok = (r_len == 11'd3);
                w_crc_ok = w_len_ok && (r_crc5 == CRC5_RESIDUAL);
            end
            KIND_DATA: begin
                w_len_ok = (r_len >= 11'd3) && (r_len <= MAX_LEN);
                w_crc_ok = w_len_ok && (r_crc16 == CRC16_RESIDUAL);
                if (r_len >= 11'd3) w_payload = r_len - 11'd3;
            end
            KIND_HANDSHAKE: begin
                w_len_ok = (r_len == 11'd1);
                w_crc_ok = 1'b1;
            end
            default: begin
                w_len_ok = 1'b0;
                w_crc_ok = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clock48 or negedge reset_n) begin
        if (!reset_n) begin
            r_len          <= '0;
            r_idx          <= '0;
            r_buf_addr     <= '0;
            r_crc5         <= '0;
            r_crc16        <= '0;
            r_busy         <= 1'b0;
            r_buf_release  <= 1'b0;
            r_result_valid <= 1'b0;
            r_pid          <= '0;
            r_kind         <= KIND_TOKEN;
            r_pid_ok       <= 1'b0;
            r_crc_ok       <= 1'b0;
            r_len_ok       <= 1'b0;
            r_addr         <= '0;
            r_endp         <= '0;
            r_frame        <= '0;
            r_payload      <= '0;
        end else begin
            r_buf_release <= 1'b0;

            if (w_accept) begin
                r_len      <= io.packet_bytes;
                r_idx      <= '0;
                r_buf_addr <= '0;
                r_busy     <= 1'b1;
                r_crc5     <= CRC5_INIT;
                r_crc16    <= CRC16_INIT;
                r_pid      <= '0;
                r_kind     <= KIND_SPECIAL;
                r_pid_ok   <= 1'b0;
                r_crc_ok   <= 1'b0;
                r_len_ok   <= 1'b0;
                r_addr     <= '0;
                r_endp     <= '0;
                r_frame    <= '0;
                r_payload  <= '0;
                if (io.packet_bytes == 11'd0) begin
                    r_result_valid <= 1'b1;
                    r_buf_release  <= 1'b1;
                end
            end

            if (w_consume) begin
                r_idx <= r_idx + 11'd1;
                // Address leads by one byte so the next word arrives exactly when lane 0 is needed.
                if (r_idx[1:0] == 2'd2) r_buf_addr <= r_buf_addr + 1'b1;
                if (r_idx == 11'd0) begin
                    r_pid    <= w_byte[3:0];
                    r_kind   <= pid_kind(w_byte);
                    r_pid_ok <= pid_check(w_byte);
                end else begin
                    r_crc16 <= w_crc16_nxt;
                    if (r_idx <= 11'd2) r_crc5 <= w_crc5_nxt;
                    if (r_kind == KIND_TOKEN && r_idx == 11'd1) begin
                        r_addr       <= w_byte[6:0];
                        r_endp[0]    <= w_byte[7];
                        r_frame[7:0] <= w_byte;
                    end
                    if (r_kind == KIND_TOKEN && r_idx == 11'd2) begin
                        r_endp[3:1]   <= w_byte[2:0];
                        r_frame[10:8] <= w_byte[2:0];
                    end
                end
            end

            if (w_finish) begin
                r_result_valid <= 1'b1;
                r_buf_release  <= 1'b1;
                r_len_ok       <= w_len_ok;
                r_crc_ok       <= w_crc_ok;
                r_payload      <= w_payload;
            end

            if (w_done) begin
                r_busy         <= 1'b0;
                r_result_valid <= 1'b0;
            end
        end
    end

    assign io.buf_addr      = r_buf_addr;
    assign io.busy          = r_busy;
    assign io.buf_release   = r_buf_release;
    assign io.result_valid  = r_result_valid;
    assign io.pid           = r_pid;
    assign io.kind          = r_kind;
    assign io.pid_ok        = r_pid_ok;
    assign io.crc_ok        = r_crc_ok;
    assign io.len_ok        = r_len_ok;
    assign io.addr          = r_addr;
    assign io.endp          = r_endp;
    assign io.frame         = r_frame;
    assign io.payload_bytes = r_payload;

endmodule

// File: tb/tb_usb_packet_parser.sv
// Directed bench for usb_packet_parser: table of packets with hand-computed decodes,
// plus hand-written backpressure, early-ready, zero-length, length-limit and mid-packet reset sequences.
module tb_usb_packet_parser;

    logic clock48 = 1'b0;
    logic reset_n = 1'b0;

    always #5 clock48 = ~clock48;

    usb_packet_parser_if #(.AW(8)) bus ();

    usb_packet_parser #(.BUF_WORDS(256), .MAX_BYTES(1024)) dut (
        .clock48 (clock48),
        .reset_n (reset_n),
        .io      (bus)
    );

    logic [31:0] mem [0:255];
    always @(posedge clock48) bus.buf_rdata <= mem[bus.buf_addr];

    int rel_cnt = 0;
    always @(posedge clock48) if (bus.buf_release === 1'b1) rel_cnt++;

    int n_checks = 0;
    int n_pass   = 0;

    typedef struct {
        string       name;
        int          n;
        logic [87:0] b;      // bytes right-justified, byte 0 most significant
        logic [3:0]  pid;
        logic [1:0]  kind;
        logic        pid_ok;
        logic        crc_ok;
        logic        len_ok;
        logic [6:0]  addr;
        logic [3:0]  endp;
        logic [10:0] frame;
        logic [10:0] payload;
    } vec_t;

    vec_t vecs [11];

    function automatic vec_t mk(input string nm, input int n, input logic [87:0] b,
                                input logic [3:0] pid, input logic [1:0] kind,
                                input logic pok, input logic cok, input logic lok,
                                input logic [6:0] addr, input logic [3:0] endp,
                                input logic [10:0] frame, input logic [10:0] pay);
        vec_t v;
        v.name = nm; v.n = n; v.b = b; v.pid = pid; v.kind = kind;
        v.pid_ok = pok; v.crc_ok = cok; v.len_ok = lok;
        v.addr = addr; v.endp = endp; v.frame = frame; v.payload = pay;
        return v;
    endfunction

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    endtask

    task automatic load(input int n, input logic [87:0] b);
        logic [7:0] byt;
        for (int w = 0; w < 4; w++) mem[w] = 32'h0;
        for (int k = 0; k < n; k++) begin
            byt = b[8*(n-1-k) +: 8];
            mem[k >> 2][8*(k & 3) +: 8] = byt;
        end
    endtask

    task automatic pulse_start(input int n);
        @(negedge clock48);
        bus.start        = 1'b1;
        bus.packet_bytes = 11'(n);
        @(posedge clock48);
        #1;
        bus.start = 1'b0;
    endtask

    task automatic wait_valid(input string nm, input int exp_lat);
        int cyc = 0;
        while (bus.result_valid !== 1'b1 && cyc < 3000) begin
            @(posedge clock48);
            #1;
            cyc++;
        end
        check({nm, " latency"}, cyc, exp_lat);
    endtask

    task automatic handshake(input string nm, input int rel0, input bit chk_rel);
        @(negedge clock48);
        bus.result_ready = 1'b1;
        @(posedge clock48);
        #1;
        bus.result_ready = 1'b0;
        check({nm, " done_valid"}, bus.result_valid, 0);
        check({nm, " done_busy"}, bus.busy, 0);
        if (chk_rel) check({nm, " release_count"}, rel_cnt - rel0, 1);
    endtask

    task automatic check_fields(input vec_t v);
        check({v.name, " busy"}, bus.busy, 1);
        check({v.name, " pid"}, bus.pid, v.pid);
        check({v.name, " kind"}, bus.kind, v.kind);
        check({v.name, " pid_ok"}, bus.pid_ok, v.pid_ok);
        check({v.name, " crc_ok"}, bus.crc_ok, v.crc_ok);
        check({v.name, " len_ok"}, bus.len_ok, v.len_ok);
        check({v.name, " addr"}, bus.addr, v.addr);
        check({v.name, " endp"}, bus.endp, v.endp);
        check({v.name, " frame"}, bus.frame, v.frame);
        check({v.name, " payload"}, bus.payload_bytes, v.payload);
    endtask

    task automatic run_vec(input vec_t v, input bit do_ack);
        int rel0;
        load(v.n, v.b);
        rel0 = rel_cnt;
        pulse_start(v.n);
        wait_valid(v.name, v.n + 2);
        check({v.name, " release_pulse"}, bus.buf_release, 1);
        check_fields(v);
        if (do_ack) handshake(v.name, rel0, 1'b1);
    endtask

    task automatic run_long(input int n, input logic exp_len_ok);
        int rel0;
        for (int w = 0; w < 256; w++) mem[w] = 32'h0;
        mem[0] = 32'h0000_00C3;
        rel0 = rel_cnt;
        pulse_start(n);
        wait_valid("long", n + 2);
        check("long kind", bus.kind, 1);
        check("long len_ok", bus.len_ok, exp_len_ok);
        check("long payload", bus.payload_bytes, n - 3);
        if (!exp_len_ok) check("long crc_ok", bus.crc_ok, 0);
        handshake("long", rel0, 1'b1);
    endtask

    initial begin
        int rel0;
        bus.start        = 1'b0;
        bus.packet_bytes = 11'd0;
        bus.result_ready = 1'b0;
        for (int w = 0; w < 256; w++) mem[w] = 32'h0;

        vecs[0]  = mk("setup_ok",   3, 88'h2D0010,  4'hD, 2'd0, 1, 1, 1, 7'h00, 4'h0, 11'h000, 11'd0);
        vecs[1]  = mk("setup_bad",  3, 88'h2D0011,  4'hD, 2'd0, 1, 0, 1, 7'h00, 4'h2, 11'h100, 11'd0);
        vecs[2]  = mk("data0_ok",  11, 88'hC3_80_06_00_01_00_00_40_00_DD_94,
                                                    4'h3, 2'd1, 1, 1, 1, 7'h00, 4'h0, 11'h000, 11'd8);
        vecs[3]  = mk("data0_bad", 11, 88'hC3_80_06_00_01_FF_00_40_00_DD_94,
                                                    4'h3, 2'd1, 1, 0, 1, 7'h00, 4'h0, 11'h000, 11'd8);
        vecs[4]  = mk("ack",        1, 88'hD2,      4'h2, 2'd2, 1, 1, 1, 7'h00, 4'h0, 11'h000, 11'd0);
        vecs[5]  = mk("bad_pid",    1, 88'h22,      4'h2, 2'd3, 0, 0, 0, 7'h00, 4'h0, 11'h000, 11'd0);
        vecs[6]  = mk("out_tok",    3, 88'hE115BD,  4'h1, 2'd0, 1, 1, 1, 7'h15, 4'hA, 11'h515, 11'd0);
        vecs[7]  = mk("sof_len4",   4, 88'hA515BD00,4'h5, 2'd0, 1, 0, 0, 7'h15, 4'hA, 11'h515, 11'd0);
        vecs[8]  = mk("data1_n2",   2, 88'h4B00,    4'hB, 2'd1, 1, 0, 0, 7'h00, 4'h0, 11'h000, 11'd0);
        vecs[9]  = mk("nak_n3",     3, 88'h5A0000,  4'hA, 2'd2, 1, 1, 0, 7'h00, 4'h0, 11'h000, 11'd0);
        vecs[10] = mk("data1_emp",  3, 88'h4B0000,  4'hB, 2'd1, 1, 1, 1, 7'h00, 4'h0, 11'h000, 11'd0);

        #1;
        check("rst busy", bus.busy, 0);
        check("rst result_valid", bus.result_valid, 0);
        check("rst buf_release", bus.buf_release, 0);
        check("rst buf_addr", bus.buf_addr, 0);
        check("rst fields", {bus.pid, bus.kind, bus.pid_ok, bus.crc_ok, bus.len_ok,
                             bus.addr, bus.endp}, 0);
        check("rst frame_payload", {bus.frame, bus.payload_bytes}, 0);
        repeat (3) @(posedge clock48);
        @(negedge clock48);
        reset_n = 1'b1;

        for (int i = 0; i < 11; i++) run_vec(vecs[i], 1'b1);

        // Backpressure: result held for 20 cycles, start mid-hold must be ignored.
        load(vecs[6].n, vecs[6].b);
        rel0 = rel_cnt;
        pulse_start(vecs[6].n);
        wait_valid("bp", vecs[6].n + 2);
        for (int i = 0; i < 20; i++) begin
            @(negedge clock48);
            bus.start        = (i == 10);
            bus.packet_bytes = 11'd1;
            @(posedge clock48);
            #1;
            check("bp hold_valid", bus.result_valid, 1);
            check("bp hold_fields", {bus.pid, bus.kind, bus.addr, bus.endp, bus.crc_ok},
                  {4'h1, 2'd0, 7'h15, 4'hA, 1'b1});
        end
        bus.start = 1'b0;
        handshake("bp", rel0, 1'b1);
        repeat (3) @(posedge clock48);
        #1;
        check("bp start_ignored", {bus.busy, bus.result_valid}, 0);
        run_vec(vecs[4], 1'b1);

        // Ready held high in advance; a start in the completing cycle is ignored.
        load(1, 88'hD2);
        @(negedge clock48);
        bus.result_ready = 1'b1;
        pulse_start(1);
        wait_valid("early_rdy", 3);
        bus.start        = 1'b1;
        bus.packet_bytes = 11'd1;
        @(posedge clock48);
        #1;
        bus.start        = 1'b0;
        bus.result_ready = 1'b0;
        check("early_rdy done", {bus.busy, bus.result_valid}, 0);
        repeat (2) @(posedge clock48);
        #1;
        check("early_rdy start_ignored", bus.busy, 0);

        // Zero-length packet goes straight to a result.
        rel0 = rel_cnt;
        pulse_start(0);
        check("zero valid", bus.result_valid, 1);
        check("zero fields", {bus.kind, bus.pid_ok, bus.crc_ok, bus.len_ok}, {2'd3, 3'b000});
        handshake("zero", rel0, 1'b0);

        run_long(1024, 1'b1);
        run_long(1025, 1'b0);

        // Reset in the middle of PARSE.
        load(vecs[2].n, vecs[2].b);
        rel0 = rel_cnt;
        pulse_start(vecs[2].n);
        repeat (6) @(posedge clock48);
        #1;
        reset_n = 1'b0;
        #1;
        check("mid_rst outputs", {bus.busy, bus.result_valid, bus.buf_release, bus.buf_addr,
                                  bus.pid, bus.kind, bus.pid_ok}, 0);
        repeat (2) @(posedge clock48);
        @(negedge clock48);
        reset_n = 1'b1;
        repeat (15) @(posedge clock48);
        #1;
        check("mid_rst no_release", rel_cnt - rel0, 0);
        check("mid_rst idle", {bus.busy, bus.result_valid}, 0);
        run_vec(vecs[2], 1'b1);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
